// File: rtl/line_lap_tracker.sv
// line_lap_tracker: measures and locks the line period of a pixel stream, feeding a pixel delay-line stage
module line_lap_tracker #(
    parameter int DATA_WIDTH     = 24,
    parameter int MAX_DELAY_LAPS = 640,
    parameter int LAP_W          = 10,
    parameter int Y_W            = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_vsync,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_de,
    output logic [LAP_W-1:0]      o_delaylap,
    output logic [LAP_W-1:0]      o_x,
    output logic [Y_W-1:0]        o_y,
    output logic                  o_locked,
    output logic                  o_err
);

    typedef enum logic [1:0] {IDLE, SEEK, CONFIRM, LOCKED} state_t;

    localparam logic [LAP_W-1:0] PC_MAX  = {LAP_W{1'b1}};
    localparam logic [LAP_W-1:0] MAX_LAP = LAP_W'(MAX_DELAY_LAPS);

    state_t           state_q;
    logic             vs_q, de_q, have_prev_q;
    logic [LAP_W-1:0] pc_q, pc_d, cand_q, x_d;
    logic [Y_W-1:0]   y_d;
    logic             vs_rise, de_rise, de_fall, cmp, valid;

    assign vs_rise = i_vsync & ~vs_q;
    assign de_rise = i_de & ~de_q;
    assign de_fall = ~i_de & de_q;
    // A frame start in the same cycle as a line start suppresses the compare.
    assign cmp     = de_rise & have_prev_q & ~vs_rise;
    // pc_q holds the clock distance since the previous de rise; saturation is never a legal period.
    assign valid   = (pc_q != '0) && (pc_q != PC_MAX) && (pc_q <= MAX_LAP);

    // Next-state for the period counter and the pixel coordinates.
    always_comb begin
        pc_d = de_rise ? LAP_W'(1) : (pc_q == PC_MAX ? pc_q : pc_q + 1'b1);
        x_d  = de_rise ? '0 : (i_de ? o_x + 1'b1 : o_x);
        y_d  = vs_rise ? '0 : (de_fall ? o_y + 1'b1 : o_y);
    end

    // One-clock data pipeline, edge-detect history, period counter and coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data      <= '0;
            o_de        <= 1'b0;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            pc_q        <= '0;
            have_prev_q <= 1'b0;
            o_x         <= '0;
            o_y         <= '0;
        end else begin
            o_data      <= i_data;
            o_de        <= i_de;
            vs_q        <= i_vsync;
            de_q        <= i_de;
            pc_q        <= pc_d;
            have_prev_q <= vs_rise ? 1'b0 : (de_rise ? 1'b1 : have_prev_q);
            o_x         <= x_d;
            o_y         <= y_d;
        end
    end

    // Lock FSM: needs two equal consecutive valid periods; frame start clears the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cand_q     <= '0;
            o_delaylap <= '0;
            o_locked   <= 1'b0;
            o_err      <= 1'b0;
        end else if (vs_rise) begin
            o_err   <= 1'b0;
            state_q <= (state_q == LOCKED) ? LOCKED : SEEK;
        end else if (cmp) begin
            case (state_q)
                SEEK: begin
                    if (valid) begin
                        cand_q  <= pc_q;
                        state_q <= CONFIRM;
                    end else begin
                        o_err <= 1'b1;
                    end
                end
                CONFIRM: begin
                    if (!valid) begin
                        o_err   <= 1'b1;
                        state_q <= SEEK;
                    end else if (pc_q == cand_q) begin
                        o_delaylap <= pc_q;
                        o_locked   <= 1'b1;
                        state_q    <= LOCKED;
                    end else begin
                        cand_q <= pc_q;
                    end
                end
                LOCKED: begin
                    if (pc_q != o_delaylap) begin
                        o_locked <= 1'b0;
                        o_err    <= 1'b1;
                        cand_q   <= valid ? pc_q : cand_q;
                        state_q  <= valid ? CONFIRM : SEEK;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_lap_tracker.sv
// tb_line_lap_tracker: table-driven line sequences with a pixel/coordinate scoreboard
module tb_line_lap_tracker;

    localparam int DW = 24;
    localparam int LW = 10;
    localparam int YW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_vsync = 1'b0;
    logic          i_de = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [DW-1:0] o_data;
    logic          o_de;
    logic [LW-1:0] o_delaylap;
    logic [LW-1:0] o_x;
    logic [YW-1:0] o_y;
    logic          o_locked;
    logic          o_err;

    line_lap_tracker #(
        .DATA_WIDTH(DW), .MAX_DELAY_LAPS(640), .LAP_W(LW), .Y_W(YW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_vsync(i_vsync), .i_de(i_de), .i_data(i_data),
        .o_data(o_data), .o_de(o_de), .o_delaylap(o_delaylap), .o_x(o_x), .o_y(o_y),
        .o_locked(o_locked), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          de;
        bit            xy;
        int            x;
        int            y;
    } exp_t;

    typedef struct {
        bit rst;
        bit vs;
        int gap;
        int hi;
        int lo;
        bit lk;
        int lap;
        bit er;
    } row_t;

    exp_t q[$];
    exp_t e;
    row_t rows[$];
    int   checks = 0;
    int   errors = 0;
    int   y_exp = 0;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_o_data"}, int'(o_data), 0);
        chk({tag, "_o_de"}, int'(o_de), 0);
        chk({tag, "_o_delaylap"}, int'(o_delaylap), 0);
        chk({tag, "_o_x"}, int'(o_x), 0);
        chk({tag, "_o_y"}, int'(o_y), 0);
        chk({tag, "_o_locked"}, int'(o_locked), 0);
        chk({tag, "_o_err"}, int'(o_err), 0);
    endtask

    // Scoreboard: each input driven at a falling edge is due at the output after the next rising edge.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("o_data", int'(o_data), int'(e.d));
            chk("o_de", int'(o_de), int'(e.de));
            if (e.xy) begin
                chk("o_x", int'(o_x), e.x);
                chk("o_y", int'(o_y), e.y);
            end
        end
    end

    task automatic drive(input logic vs, input logic de, input bit xy, input int x, input int y);
        @(negedge clk);
        i_vsync = vs;
        i_de    = de;
        i_data  = DW'($urandom);
        q.push_back('{d: i_data, de: de, xy: xy, x: x, y: y});
    endtask

    task automatic add(input bit rst, input bit vs, input int gap, input int hi, input int lo,
                       input bit lk, input int lap, input bit er);
        rows.push_back('{rst: rst, vs: vs, gap: gap, hi: hi, lo: lo, lk: lk, lap: lap, er: er});
    endtask

    task automatic run_row(input int idx, input row_t r);
        if (r.rst) begin
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk_zero($sformatf("midrst%0d", idx));
            i_vsync = 1'b0;
            i_de    = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            y_exp = 0;
        end
        if (r.vs) begin
            repeat (2) drive(1'b1, 1'b0, 1'b0, 0, 0);
            repeat (r.gap) drive(1'b0, 1'b0, 1'b0, 0, 0);
            y_exp = 0;
        end
        for (int k = 0; k < r.hi; k++) begin
            drive(1'b0, 1'b1, 1'b1, k, y_exp);
            if (k == 0) begin
                @(posedge clk);
                #2;
                chk($sformatf("row%0d_locked", idx), int'(o_locked), int'(r.lk));
                chk($sformatf("row%0d_delaylap", idx), int'(o_delaylap), r.lap);
                chk($sformatf("row%0d_err", idx), int'(o_err), int'(r.er));
            end
        end
        repeat (r.lo) drive(1'b0, 1'b0, 1'b0, 0, 0);
        y_exp++;
    endtask

    initial begin
        // Expectations are sampled one clock after each line's first pixel, so they reflect
        // the period of the preceding line (hi+lo of the previous row).
        add(0, 0, 0,    90,  10, 0, 0,   0);
        add(0, 0, 0,    90,  10, 0, 0,   0);
        add(0, 0, 0,    90,  10, 0, 0,   0);
        add(0, 1, 20,   600, 40, 0, 0,   0);
        add(0, 0, 0,    600, 40, 0, 0,   0);
        add(0, 0, 0,    600, 40, 1, 640, 0);
        add(0, 0, 0,    600, 40, 1, 640, 0);
        add(0, 1, 20,   90,  10, 1, 640, 0);
        add(0, 0, 0,    90,  10, 0, 640, 1);
        add(0, 0, 0,    90,  11, 1, 100, 1);
        add(0, 0, 0,    90,  10, 0, 100, 1);
        add(0, 0, 0,    90,  10, 0, 100, 1);
        add(0, 0, 0,    90,  10, 1, 100, 1);
        add(0, 0, 0,    90,  10, 1, 100, 1);
        add(0, 1, 5000, 90,  10, 1, 100, 0);
        add(0, 0, 0,    90,  10, 1, 100, 0);
        add(0, 0, 0,    90,  10, 1, 100, 0);
        add(1, 0, 0,    90,  10, 0, 0,   0);
        add(0, 0, 0,    90,  10, 0, 0,   0);
        add(0, 0, 0,    90,  10, 0, 0,   0);
        add(0, 1, 20,   90,  10, 0, 0,   0);
        add(0, 0, 0,    90,  11, 0, 0,   0);
        add(0, 0, 0,    90,  11, 0, 0,   0);
        add(0, 0, 0,    90,  10, 1, 101, 0);
        add(0, 0, 0,    90,  10, 0, 101, 1);
        add(1, 1, 20,   700, 100, 0, 0,  0);
        add(0, 0, 0,    700, 100, 0, 0,  1);
        add(0, 0, 0,    700, 100, 0, 0,  1);
        add(0, 0, 0,    90,  10, 0, 0,   1);
        add(0, 1, 20,   90,  10, 0, 0,   0);
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < rows.size(); i++) run_row(i, rows[i]);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
